// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for serial_adder_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell plus a carry register, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nxt;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             cout_q;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last;

    assign fa_s   = sa[0] ^ sb[0] ^ cy;
    assign fa_c   = (sa[0] & sb[0]) | (sa[0] & cy) | (sb[0] & cy);
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // Result bits enter from the MSB side so the LSB lands at bit 0 last.
    always_comb begin
        sum_nxt            = sum_q >> 1;
        sum_nxt[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            cy     <= 1'b0;
            cout_q <= 1'b0;
        end else if (accept) begin
            state <= RUN;
            sa    <= bus.a;
            sb    <= bus.b;
            cy    <= bus.cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            cy    <= fa_c;
            sum_q <= sum_nxt;
            cnt   <= cnt + CW'(1);
            if (last) begin
                state  <= DONE;
                cout_q <= fa_c;
            end
        end else begin
            state <= IDLE;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // On the MSB step, cy is the carry into the MSB and fa_c the carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!accept && last) begin
            ovf_q <= cy ^ fa_c;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_adder_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;

    serial_adder_ctrl_if #(.WIDTH(8)) bus ();

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`endif
    endtask

    // Drive a request in the current cycle and record the model's answer.
    task automatic launch(input logic [7:0] x, input logic [7:0] y,
                          input logic c);
        logic [8:0] full;
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        bus.cin   = c;
        full      = 9'(x) + 9'(y) + 9'(c);
        exp_sum   = full[7:0];
        exp_cout  = full[8];
        exp_ovf   = (x[7] == y[7]) && (exp_sum[7] != x[7]);
    endtask

    // Accept edge, eight busy cycles with scrambled inputs, then done cycle.
    task automatic finish_op(input int poke);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_run", 32'(bus.busy), 32'd1);
            chk("done_run", 32'(bus.done), 32'd0);
            bus.start = (i + 1 == poke);
            bus.a     = 8'($urandom);
            bus.b     = 8'($urandom);
            bus.cin   = 1'($urandom);
        end
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_done", 32'(bus.busy), 32'd0);
        chk_result("res");
    endtask

    task automatic idle_chk();
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_idle", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk_result("hold");
    endtask

    initial begin
        int seen;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        exp_sum   = '0;
        exp_cout  = 1'b0;
        exp_ovf   = 1'b0;

        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk_result("rst");

        // First start right at release must be taken on the next edge.
        rst = 1'b0;
        launch(8'h0F, 8'h01, 1'b0);
        finish_op(0);
        idle_chk();

        launch(8'hFF, 8'h01, 1'b0);
        finish_op(0);
        idle_chk();
        launch(8'hFF, 8'h00, 1'b1);
        finish_op(0);
        idle_chk();
        launch(8'h7F, 8'h01, 1'b0);
        finish_op(0);
        idle_chk();
        launch(8'h80, 8'h80, 1'b0);
        finish_op(0);
        idle_chk();

        // Start during RUN cycle 3 must be ignored.
        launch(8'h12, 8'h34, 1'b0);
        finish_op(3);
        idle_chk();

        // Back-to-back: start held in the DONE cycle.
        launch(8'hA5, 8'h3C, 1'b1);
        finish_op(0);
        launch(8'h01, 8'h01, 1'b0);
        finish_op(0);
        idle_chk();

        // Reset during RUN cycle 4 aborts without a done pulse.
        launch(8'h55, 8'h66, 1'b0);
        @(posedge clk);
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk_result("abort");
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        rst = 1'b0;
        launch(8'h21, 8'h43, 1'b0);
        finish_op(0);
        idle_chk();

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 0) idle_chk();
            launch(8'($urandom), 8'($urandom), 1'($urandom));
            finish_op(int'($urandom_range(0, 7)));
        end
        idle_chk();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 busy  output  1  high while bits are being processed (state RUN).
REQ-009 done  output  1  single-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  result, registered.
REQ-011 cout  output  1  final carry-out, registered.
REQ-012 ovf  output  1  signed overflow, registered; present only per REQ-030.

Function
REQ-013 The block SHALL compute a+b+cin bit-serially, LSB first, using exactly one one-bit full-adder cell (sum = x^y^c, carry = majority(x,y,c)) plus a carry register.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, with the state encoding internal.
REQ-015 Start is accepted on a rising edge with start=1 in IDLE or DONE: a and b go to shift registers, cin to the carry register, and the bit counter is cleared; next state is RUN.
REQ-016 In RUN, each edge SHALL add the current LSBs with the carry register, shift the result bit into sum from the MSB side, update the carry register and increment the counter.
REQ-017 After the WIDTH-th RUN edge, the next state SHALL be DONE; sum holds the full result and cout equals the carry register.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high for exactly the cycle following edge k+WIDTH; busy SHALL be high in the cycles following edges k..k+WIDTH-1.
REQ-019 In DONE, done=1 and busy=0; the next state is IDLE, or RUN if start=1 (back-to-back, with no idle cycle).
REQ-020 start=1 during RUN SHALL be ignored; the in-flight operation SHALL complete unaltered.
REQ-021 Changes on a, b and cin outside the accepting edge SHALL NOT affect the result.
REQ-022 sum, cout and ovf SHALL hold their last result through IDLE until the next accepted start; during RUN, sum holds partial shift contents and is not valid.
REQ-023 With WIDTH=1, RUN SHALL last exactly one cycle.
REQ-024 The counter width SHALL be the minimum needed to count to WIDTH, and it SHALL NOT wrap before reaching WIDTH.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, independent of clk.
REQ-026 Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; the carry register, counter and shift registers are cleared.
REQ-027 Reset mid-RUN SHALL abort the operation with no done pulse.
REQ-028 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-029 The macro SERIAL_ADD_OVF_EN SHALL control signed-overflow support.
REQ-030 With SERIAL_ADD_OVF_EN defined:
- port ovf exists.
- On entering DONE, ovf is set to (carry into MSB) XOR (carry out of MSB).
- ovf is held and reset per REQ-022 and REQ-026.
REQ-031 Without SERIAL_ADD_OVF_EN:
- port ovf and its logic are absent.
- All other behaviour is identical.

Verification (WIDTH=8)
REQ-032 a=0x0F, b=0x01, cin=0, start accepted at edge k -> done at cycle k+8 only, sum=0x10, cout=0, busy high for 8 cycles.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-034 a=0x7F, b=0x01 with SERIAL_ADD_OVF_EN -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-035 Start with a=0x12, b=0x34, then start=1 with a=0xFF in RUN cycle 3 -> single done, sum=0x46.
REQ-036 Start held high through the DONE cycle with new operands 0x01+0x01 -> second done exactly 9 cycles after the first, sum=0x02.
REQ-037 rst pulsed in RUN cycle 4 -> busy=0, sum=0, and no done pulse; a start after release completes normally.
